// File: rtl/rtc_ctrl_if.sv
// Host-side load/alarm bus for rtc_ctrl: time-load handshake plus alarm programming.
interface rtc_ctrl_if;
  logic        set_valid;
  logic        set_ready;
  logic [23:0] set_time;
  logic        set_err;
  logic        alarm_wr;
  logic [23:0] alarm_time;
  logic        alarm_clr;

  modport master (
    output set_valid, set_time, alarm_wr, alarm_time, alarm_clr,
    input  set_ready, set_err
  );

  modport slave (
    input  set_valid, set_time, alarm_wr, alarm_time, alarm_clr,
    output set_ready, set_err
  );
endinterface

// File: rtl/rtc_ctrl.sv
// BCD real-time clock sequencer: 1 Hz prescaler, hh:mm:ss counter, checked time loads.
// Optional alarm comparator is built when RTC_ALARM_EN is defined.
module rtc_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  rtc_ctrl_if.slave   bus,
  output logic [23:0] time_out,
  output logic        tick_1hz,
  output logic        day_rollover,
  output logic        alarm_hit
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, CHECK, LOAD} state_t;

  state_t          state_r;
  logic [PW-1:0]   pc_r;
  logic [23:0]     time_r;
  logic [23:0]     shadow_r;
  logic            tick_r;
  logic            roll_r;
  logic            set_ready_r;
  logic            set_err_r;
  logic            alarm_hit_r;

  logic            tick_s;
  logic            accept_s;
  logic [23:0]     next_time_s;
  logic            load_err_s;
  logic            alarm_err_s;
  logic            hit_s;

  function automatic logic time_ok(input logic [23:0] t);
    time_ok = (t[3:0]   <= 4'd9) && (t[7:4]   <= 4'd5) &&
              (t[11:8]  <= 4'd9) && (t[15:12] <= 4'd5) &&
              (t[19:16] <= 4'd9) && (t[23:16] <= 8'h23);
  endfunction

  function automatic logic [23:0] bcd_inc(input logic [23:0] t);
    logic [23:0] n;
    n = t;
    if (t[3:0] != 4'd9) begin
      n[3:0] = t[3:0] + 4'd1;
    end else begin
      n[3:0] = 4'd0;
      if (t[7:4] != 4'd5) begin
        n[7:4] = t[7:4] + 4'd1;
      end else begin
        n[7:4] = 4'd0;
        if (t[11:8] != 4'd9) begin
          n[11:8] = t[11:8] + 4'd1;
        end else begin
          n[11:8] = 4'd0;
          if (t[15:12] != 4'd5) begin
            n[15:12] = t[15:12] + 4'd1;
          end else begin
            n[15:12] = 4'd0;
            if (t[23:16] == 8'h23) begin
              n[23:16] = 8'h00;
            end else if (t[19:16] == 4'd9) begin
              n[19:16] = 4'd0;
              n[23:20] = t[23:20] + 4'd1;
            end else begin
              n[19:16] = t[19:16] + 4'd1;
            end
          end
        end
      end
    end
    bcd_inc = n;
  endfunction

  assign tick_s      = (state_r == RUN) && (pc_r == PW'(TICK_DIV - 1));
  assign accept_s    = bus.set_valid && set_ready_r;
  assign next_time_s = bcd_inc(time_r);
  assign load_err_s  = (state_r == CHECK) && !time_ok(shadow_r);

`ifdef RTC_ALARM_EN
  logic [23:0] alarm_r;
  logic        armed_r;

  // Alarm register: clear beats a same-cycle write; an out-of-range write disarms.
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_r <= 24'h000000;
      armed_r <= 1'b0;
    end else if (bus.alarm_clr) begin
      armed_r <= 1'b0;
    end else if (bus.alarm_wr) begin
      if (time_ok(bus.alarm_time)) begin
        alarm_r <= bus.alarm_time;
        armed_r <= 1'b1;
      end else begin
        armed_r <= 1'b0;
      end
    end else begin
      armed_r <= armed_r;
    end
  end

  assign alarm_err_s = bus.alarm_wr && !bus.alarm_clr && !time_ok(bus.alarm_time);
  assign hit_s       = armed_r && (next_time_s == alarm_r);
`else
  logic unused_alarm;
  assign unused_alarm = ^{bus.alarm_wr, bus.alarm_time, bus.alarm_clr};
  assign alarm_err_s  = 1'b0;
  assign hit_s        = 1'b0;
`endif

  // Load FSM, prescaler, time counter and all registered pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      pc_r        <= '0;
      time_r      <= 24'h000000;
      shadow_r    <= 24'h000000;
      tick_r      <= 1'b0;
      roll_r      <= 1'b0;
      set_ready_r <= 1'b1;
      set_err_r   <= 1'b0;
      alarm_hit_r <= 1'b0;
    end else begin
      tick_r      <= 1'b0;
      roll_r      <= 1'b0;
      alarm_hit_r <= 1'b0;
      set_err_r   <= load_err_s || alarm_err_s;
      case (state_r)
        IDLE, RUN: begin
          if (state_r == RUN) begin
            pc_r <= tick_s ? '0 : pc_r + PW'(1);
          end
          if (accept_s) begin
            // A tick on the accept edge is dropped; the load takes over.
            shadow_r    <= bus.set_time;
            state_r     <= CHECK;
            set_ready_r <= 1'b0;
          end else begin
            state_r     <= run ? RUN : IDLE;
            set_ready_r <= 1'b1;
            if (tick_s) begin
              time_r      <= next_time_s;
              tick_r      <= 1'b1;
              roll_r      <= (next_time_s == 24'h000000);
              alarm_hit_r <= hit_s;
            end
          end
        end
        CHECK: begin
          if (time_ok(shadow_r)) begin
            state_r     <= LOAD;
            set_ready_r <= 1'b0;
          end else begin
            state_r     <= run ? RUN : IDLE;
            set_ready_r <= 1'b1;
          end
        end
        LOAD: begin
          time_r      <= shadow_r;
          pc_r        <= '0;
          state_r     <= run ? RUN : IDLE;
          set_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= IDLE;
          set_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign time_out      = time_r;
  assign tick_1hz      = tick_r;
  assign day_rollover  = roll_r;
  assign alarm_hit     = alarm_hit_r;
  assign bus.set_ready = set_ready_r;
  assign bus.set_err   = set_err_r;

endmodule
